frame_swap_controller: RTL and testbench

//  Single-clock N-buffer (2..4) frame-buffer ownership manager for the pipeline tail; generalises the fixed A/B double-buffer swap.

---
 rtl/frame_swap_pkg.sv | 23 ++
 rtl/lowest_free_picker.sv | 32 +++
 rtl/frame_swap_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_frame_swap_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_swap_pkg.sv
// ---------------------------------------------------------------------------
// frame_swap_pkg
//   Shared types for the frame-buffer ownership manager: the per-buffer role
//   encoding, the swap controller state encoding, and the buffer-count limit.
// ---------------------------------------------------------------------------
package frame_swap_pkg;

    localparam int MAX_BUFFERS = 4;

    typedef enum logic [1:0] {
        ROLE_FREE    = 2'd0,
        ROLE_DRAWING = 2'd1,
        ROLE_READY   = 2'd2,
        ROLE_DISPLAY = 2'd3
    } buf_role_t;

    typedef enum logic [1:0] {
        S_DRAW      = 2'd0,  // drawer owns a buffer and is rendering
        S_WAIT_FREE = 2'd1,  // frame handed over, no FREE buffer to grant yet
        S_WAIT_SLOT = 2'd2   // drawer finished but the pending slot is occupied
    } swap_state_t;

endpackage

// File: rtl/lowest_free_picker.sv
// ---------------------------------------------------------------------------
// lowest_free_picker
//   Combinational search for the lowest-index buffer whose role is FREE.
//   Ports:
//     i_roles  in   role of every buffer
//     o_found  out  at least one buffer is FREE
//     o_idx    out  lowest FREE index (0 when none found)
// ---------------------------------------------------------------------------
module lowest_free_picker
    import frame_swap_pkg::*;
#(
    parameter  int NUM_BUFFERS = 3,
    localparam int IDX_W       = $clog2(NUM_BUFFERS)
) (
    input  buf_role_t        i_roles [NUM_BUFFERS],
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (i_roles[i] == ROLE_FREE) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/frame_swap_controller.sv
// ---------------------------------------------------------------------------
// frame_swap_controller
//   N-buffer (2..4) frame-buffer ownership manager. Tracks which buffer the
//   drawer renders into, which one the display scans out and at most one
//   finished (pending) frame; presents on vblank or immediately, with an
//   optional drop-stale mailbox policy and saturating frame statistics.
//   Ports:
//     clk, rstn                 clock, asynchronous active-low reset
//     mode_immediate            present as soon as a frame is pending
//     mode_drop_stale           newer finished frame replaces pending one
//     vblank_start, draw_done   one-cycle pulses, already synchronous to clk
//     draw_grant                one-cycle pulse: draw_idx names a fresh buffer
//     draw_idx, disp_idx        drawer / display buffer indices
//     pending_valid             a finished frame awaits presentation
//     frames_shown/dropped/repeated  saturating statistics
//     err_protocol              sticky: draw_done while drawer holds no grant
// ---------------------------------------------------------------------------
module frame_swap_controller
    import frame_swap_pkg::*;
#(
    parameter  int NUM_BUFFERS = 3,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = $clog2(NUM_BUFFERS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mode_immediate,
    input  logic             mode_drop_stale,
    input  logic             vblank_start,
    input  logic             draw_done,
    output logic             draw_grant,
    output logic [IDX_W-1:0] draw_idx,
    output logic [IDX_W-1:0] disp_idx,
    output logic             pending_valid,
    output logic [CNT_W-1:0] frames_shown,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated,
    output logic             err_protocol
);

    if (NUM_BUFFERS < 2 || NUM_BUFFERS > MAX_BUFFERS) begin : g_bad_num_buffers
        $error("frame_swap_controller: NUM_BUFFERS must be in 2..4");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    buf_role_t        r_role [NUM_BUFFERS];
    swap_state_t      r_state;
    logic [IDX_W-1:0] r_draw_idx;
    logic [IDX_W-1:0] r_disp_idx;
    logic [IDX_W-1:0] r_ready_idx;
    logic             r_pending;
    logic             r_grant;
    logic [CNT_W-1:0] r_shown;
    logic [CNT_W-1:0] r_dropped;
    logic [CNT_W-1:0] r_repeated;
    logic             r_err;

    logic             w_present;
    buf_role_t        w_role_pp [NUM_BUFFERS];
    logic [IDX_W-1:0] w_disp_pp;
    logic             w_pending_pp;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;

    buf_role_t        w_role_nx [NUM_BUFFERS];
    swap_state_t      w_state_nx;
    logic [IDX_W-1:0] w_draw_nx;
    logic [IDX_W-1:0] w_ready_nx;
    logic             w_pending_nx;
    logic             w_grant_nx;
    logic             w_drop_evt;
    logic             w_err_nx;

    assign w_present = r_pending & (vblank_start | mode_immediate);

    // Presentation is resolved first; completion below sees post-present roles.
    always_comb begin
        w_role_pp    = r_role;
        w_disp_pp    = r_disp_idx;
        w_pending_pp = r_pending;
        if (w_present) begin
            w_role_pp[r_disp_idx]  = ROLE_FREE;
            w_role_pp[r_ready_idx] = ROLE_DISPLAY;
            w_disp_pp              = r_ready_idx;
            w_pending_pp           = 1'b0;
        end
    end

    lowest_free_picker #(
        .NUM_BUFFERS(NUM_BUFFERS)
    ) u_picker (
        .i_roles (w_role_pp),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    always_comb begin
        w_role_nx    = w_role_pp;
        w_state_nx   = r_state;
        w_draw_nx    = r_draw_idx;
        w_ready_nx   = r_ready_idx;
        w_pending_nx = w_pending_pp;
        w_grant_nx   = 1'b0;
        w_drop_evt   = 1'b0;
        w_err_nx     = r_err;
        case (r_state)
            S_DRAW: begin
                if (draw_done) begin
                    if (!w_pending_pp) begin
                        w_role_nx[r_draw_idx] = ROLE_READY;
                        w_ready_nx            = r_draw_idx;
                        w_pending_nx          = 1'b1;
                        if (w_free_found) begin
                            w_role_nx[w_free_idx] = ROLE_DRAWING;
                            w_draw_nx             = w_free_idx;
                            w_grant_nx            = 1'b1;
                        end else begin
                            w_state_nx = S_WAIT_FREE;
                        end
                    end else if (mode_drop_stale) begin
                        // Stale frame's buffer goes FREE and is re-granted at once.
                        w_role_nx[r_ready_idx] = ROLE_DRAWING;
                        w_role_nx[r_draw_idx]  = ROLE_READY;
                        w_ready_nx             = r_draw_idx;
                        w_draw_nx              = r_ready_idx;
                        w_grant_nx             = 1'b1;
                        w_drop_evt             = 1'b1;
                    end else begin
                        w_state_nx = S_WAIT_SLOT;
                    end
                end
            end
            S_WAIT_FREE: begin
                if (draw_done) w_err_nx = 1'b1;
                if (w_free_found) begin
                    w_role_nx[w_free_idx] = ROLE_DRAWING;
                    w_draw_nx             = w_free_idx;
                    w_grant_nx            = 1'b1;
                    w_state_nx            = S_DRAW;
                end
            end
            S_WAIT_SLOT: begin
                if (draw_done) w_err_nx = 1'b1;
                // The held frame takes the slot just vacated; the ex-display
                // buffer becomes the new draw target.
                if (w_present) begin
                    w_role_nx[r_draw_idx] = ROLE_READY;
                    w_role_nx[r_disp_idx] = ROLE_DRAWING;
                    w_ready_nx            = r_draw_idx;
                    w_draw_nx             = r_disp_idx;
                    w_pending_nx          = 1'b1;
                    w_grant_nx            = 1'b1;
                    w_state_nx            = S_DRAW;
                end
            end
            default: w_state_nx = S_DRAW;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                r_role[i] <= (i == 0) ? ROLE_DISPLAY :
                             (i == 1) ? ROLE_DRAWING : ROLE_FREE;
            end
            r_state     <= S_DRAW;
            r_draw_idx  <= IDX_W'(1);
            r_disp_idx  <= '0;
            r_ready_idx <= '0;
            r_pending   <= 1'b0;
            r_grant     <= 1'b0;
            r_shown     <= '0;
            r_dropped   <= '0;
            r_repeated  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_role      <= w_role_nx;
            r_state     <= w_state_nx;
            r_draw_idx  <= w_draw_nx;
            r_disp_idx  <= w_disp_pp;
            r_ready_idx <= w_ready_nx;
            r_pending   <= w_pending_nx;
            r_grant     <= w_grant_nx;
            r_err       <= w_err_nx;
            if (w_present)                    r_shown    <= sat_inc(r_shown);
            if (w_drop_evt)                   r_dropped  <= sat_inc(r_dropped);
            if (vblank_start && !r_pending)   r_repeated <= sat_inc(r_repeated);
        end
    end

    assign draw_grant      = r_grant;
    assign draw_idx        = r_draw_idx;
    assign disp_idx        = r_disp_idx;
    assign pending_valid   = r_pending;
    assign frames_shown    = r_shown;
    assign frames_dropped  = r_dropped;
    assign frames_repeated = r_repeated;
    assign err_protocol    = r_err;

    int w_n_disp;
    int w_n_draw;
    int w_n_ready;

    always_comb begin
        w_n_disp  = 0;
        w_n_draw  = 0;
        w_n_ready = 0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (r_role[i] == ROLE_DISPLAY) w_n_disp++;
            if (r_role[i] == ROLE_DRAWING) w_n_draw++;
            if (r_role[i] == ROLE_READY)   w_n_ready++;
        end
    end

    a_one_display: assert property (@(posedge clk) disable iff (!rstn) w_n_disp == 1);
    a_le1_drawing: assert property (@(posedge clk) disable iff (!rstn) w_n_draw <= 1);
    a_le1_ready:   assert property (@(posedge clk) disable iff (!rstn) w_n_ready <= 1);
    a_ready_pend:  assert property (@(posedge clk) disable iff (!rstn) (w_n_ready == 1) == r_pending);
    a_idx_differ:  assert property (@(posedge clk) disable iff (!rstn) r_draw_idx != r_disp_idx);
    a_grant_pulse: assert property (@(posedge clk) disable iff (!rstn) r_grant |=> !r_grant);

endmodule

// File: tb/tb_frame_swap_controller.sv
module tb_frame_swap_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0;

    // dut3: NUM_BUFFERS=3, CNT_W=16
    logic        a_imm = 0, a_drop = 0, a_vb = 0, a_dd = 0;
    logic        a_grant, a_pend, a_err;
    logic [1:0]  a_draw, a_disp;
    logic [15:0] a_shown, a_dropped, a_rep;

    // dut2: NUM_BUFFERS=2, CNT_W=2 (small counters to reach saturation)
    logic        b_imm = 0, b_drop = 0, b_vb = 0, b_dd = 0;
    logic        b_grant, b_pend, b_err;
    logic [0:0]  b_draw, b_disp;
    logic [1:0]  b_shown, b_dropped, b_rep;

    frame_swap_controller #(.NUM_BUFFERS(3), .CNT_W(16)) dut3 (
        .clk(clk), .rstn(rstn),
        .mode_immediate(a_imm), .mode_drop_stale(a_drop),
        .vblank_start(a_vb), .draw_done(a_dd),
        .draw_grant(a_grant), .draw_idx(a_draw), .disp_idx(a_disp),
        .pending_valid(a_pend), .frames_shown(a_shown),
        .frames_dropped(a_dropped), .frames_repeated(a_rep),
        .err_protocol(a_err)
    );

    frame_swap_controller #(.NUM_BUFFERS(2), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn),
        .mode_immediate(b_imm), .mode_drop_stale(b_drop),
        .vblank_start(b_vb), .draw_done(b_dd),
        .draw_grant(b_grant), .draw_idx(b_draw), .disp_idx(b_disp),
        .pending_valid(b_pend), .frames_shown(b_shown),
        .frames_dropped(b_dropped), .frames_repeated(b_rep),
        .err_protocol(b_err)
    );

    typedef struct {
        int sel;
        int draw, disp, pend, grant, shown, drop, rep, err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    int total = 0;
    int bad   = 0;

    int e_draw, e_disp, e_pend, e_grant, e_shown, e_drop, e_rep, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_reset_exp();
        e_draw = 1; e_disp = 0; e_pend = 0; e_grant = 0;
        e_shown = 0; e_drop = 0; e_rep = 0; e_err = 0;
    endtask

    task automatic push_exp(input int sel, input string tag);
        exp_t e;
        e.sel = sel;   e.draw = e_draw; e.disp = e_disp; e.pend = e_pend;
        e.grant = e_grant; e.shown = e_shown; e.drop = e_drop;
        e.rep = e_rep; e.err = e_err;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        e_grant = 0;
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        if (e.sel == 3) begin
            chk({t, ".draw_idx"},  32'(a_draw),    e.draw);
            chk({t, ".disp_idx"},  32'(a_disp),    e.disp);
            chk({t, ".pending"},   32'(a_pend),    e.pend);
            chk({t, ".grant"},     32'(a_grant),   e.grant);
            chk({t, ".shown"},     32'(a_shown),   e.shown);
            chk({t, ".dropped"},   32'(a_dropped), e.drop);
            chk({t, ".repeated"},  32'(a_rep),     e.rep);
            chk({t, ".err"},       32'(a_err),     e.err);
        end else begin
            chk({t, ".draw_idx"},  32'(b_draw),    e.draw);
            chk({t, ".disp_idx"},  32'(b_disp),    e.disp);
            chk({t, ".pending"},   32'(b_pend),    e.pend);
            chk({t, ".grant"},     32'(b_grant),   e.grant);
            chk({t, ".shown"},     32'(b_shown),   e.shown);
            chk({t, ".dropped"},   32'(b_dropped), e.drop);
            chk({t, ".repeated"},  32'(b_rep),     e.rep);
            chk({t, ".err"},       32'(b_err),     e.err);
        end
    endtask

    // Drive one cycle of pulses on the selected DUT; expected post-edge
    // values come from the e_* variables set by the caller.
    task automatic cyc(input int sel, input string tag, input logic vb, input logic dd);
        if (sel == 3) begin a_vb = vb; a_dd = dd; end
        else          begin b_vb = vb; b_dd = dd; end
        push_exp(sel, tag);
        @(posedge clk);
        #1;
        a_vb = 0; a_dd = 0; b_vb = 0; b_dd = 0;
        check_out();
    endtask

    task automatic do_reset();
        rstn = 0;
        a_imm = 0; a_drop = 0; a_vb = 0; a_dd = 0;
        b_imm = 0; b_drop = 0; b_vb = 0; b_dd = 0;
        repeat (2) @(posedge clk);
        #1;
        set_reset_exp();
        push_exp(3, "rst3"); check_out();
        push_exp(2, "rst2"); check_out();
        rstn = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        // ---------------- reset + basic present (N=3) ----------------
        do_reset();
        cyc(3, "idle", 0, 0);
        e_rep = 1;
        cyc(3, "vb_repeat", 1, 0);
        e_pend = 1; e_draw = 2; e_grant = 1;
        cyc(3, "dd_first", 0, 1);
        cyc(3, "post_grant", 0, 0);
        e_disp = 1; e_pend = 0; e_shown = 1;
        cyc(3, "vb_present", 1, 0);
        e_draw = 0; e_pend = 1; e_grant = 1;     // buf0 was freed by the present
        cyc(3, "dd_reuse0", 0, 1);
        cyc(3, "idle2", 0, 0);
        e_disp = 2; e_pend = 0; e_shown = 2;
        cyc(3, "vb_present2", 1, 0);

        // ---------------- drop-stale then stall (N=3) ----------------
        do_reset();
        a_drop = 1;
        e_pend = 1; e_draw = 2; e_grant = 1;
        cyc(3, "ds_dd1", 0, 1);
        cyc(3, "ds_idle1", 0, 0);
        e_draw = 1; e_drop = 1; e_grant = 1;
        cyc(3, "ds_dd2", 0, 1);
        cyc(3, "ds_idle2", 0, 0);
        a_drop = 0;
        cyc(3, "stall_dd", 0, 1);
        for (int k = 0; k < 3; k++) cyc(3, "stall_idle", 0, 0);
        e_disp = 2; e_shown = 1; e_draw = 0; e_pend = 1; e_grant = 1;
        cyc(3, "slot_vb", 1, 0);
        cyc(3, "slot_idle", 0, 0);

        // ---------------- same-cycle vblank & draw_done, protocol error ----
        e_disp = 1; e_shown = 2; e_draw = 2; e_pend = 1; e_grant = 1;
        cyc(3, "same_cycle", 1, 1);
        cyc(3, "same_idle", 0, 0);
        cyc(3, "dd_to_slot", 0, 1);
        e_err = 1;
        cyc(3, "dd_in_wait", 0, 1);
        cyc(3, "err_sticky", 0, 0);
        e_disp = 0; e_shown = 3; e_draw = 1; e_pend = 1; e_grant = 1;
        cyc(3, "slot_vb2", 1, 0);
        cyc(3, "slot_idle2", 0, 0);
        e_disp = 2; e_shown = 4; e_pend = 0;
        cyc(3, "vb_present3", 1, 0);

        // ---------------- immediate mode and reset mid-wait (N=3) ----
        do_reset();
        a_imm = 1;
        e_pend = 1; e_draw = 2; e_grant = 1;
        cyc(3, "imm_dd", 0, 1);
        e_disp = 1; e_pend = 0; e_shown = 1;
        cyc(3, "imm_show", 0, 0);
        cyc(3, "imm_idle", 0, 0);
        a_imm = 0;
        e_draw = 0; e_pend = 1; e_grant = 1;
        cyc(3, "pre_slot_dd", 0, 1);
        cyc(3, "pre_slot_idle", 0, 0);
        cyc(3, "enter_slot", 0, 1);
        rstn = 0;
        #1;
        set_reset_exp();
        push_exp(3, "async_rst"); check_out();
        cyc(3, "in_rst", 0, 0);
        rstn = 1;
        cyc(3, "post_rst1", 0, 0);
        cyc(3, "post_rst2", 0, 0);
        e_pend = 1; e_draw = 2; e_grant = 1;
        cyc(3, "post_rst_dd", 0, 1);

        // ---------------- N=2: wait-for-free and saturation ----------
        do_reset();
        e_pend = 1;
        cyc(2, "n2_dd", 0, 1);
        cyc(2, "n2_wait", 0, 0);
        e_disp = 1; e_pend = 0; e_shown = 1; e_draw = 0; e_grant = 1;
        cyc(2, "n2_vb", 1, 0);
        cyc(2, "n2_idle", 0, 0);
        for (int k = 0; k < 4; k++) begin
            e_rep = (k < 3) ? k + 1 : 3;
            cyc(2, "n2_rep_sat", 1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            e_pend = 1;
            cyc(2, "n2_loop_dd", 0, 1);
            d = e_draw;
            e_draw = e_disp; e_disp = d;
            e_pend = 0; e_grant = 1;
            e_shown = (e_shown < 3) ? e_shown + 1 : 3;
            cyc(2, "n2_loop_vb", 1, 0);
            cyc(2, "n2_loop_idle", 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
